// File: rtl/iomem_periph_hub.sv
// iomem_periph_hub: picosoc iomem interconnect fanning one master port out to
// NUM_SLAVES equal-size address windows, with a per-access timeout.
// Unmapped and timed-out accesses complete with ERR_DATA.
// Ports:
//   clk_i, reset_i         clock and synchronous active-high reset
//   m_*                    iomem master side (valid/ready/wstrb/addr/wdata/rdata)
//   s_valid_o              one-hot request to the selected slave
//   s_wstrb_o/s_addr_o/s_wdata_o  registered request payload, shared by all slaves
//   s_ready_i/s_rdata_i    per-slave completion and read data (slave k at [32k+:32])
//   err_clear_i            clears err_count_o and timeout_flag_o
//   err_count_o            saturating count of miss and timeout events
//   timeout_flag_o         sticky timeout indicator
module iomem_periph_hub #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int unsigned WIN_BITS   = 12,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       m_valid_i,
    output logic                       m_ready_o,
    input  logic [3:0]                 m_wstrb_i,
    input  logic [31:0]                m_addr_i,
    input  logic [31:0]                m_wdata_i,
    output logic [31:0]                m_rdata_o,
    output logic [NUM_SLAVES-1:0]      s_valid_o,
    output logic [3:0]                 s_wstrb_o,
    output logic [WIN_BITS-1:0]        s_addr_o,
    output logic [31:0]                s_wdata_o,
    input  logic [NUM_SLAVES-1:0]      s_ready_i,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata_i,
    input  logic                       err_clear_i,
    output logic [7:0]                 err_count_o,
    output logic                       timeout_flag_o
);

    localparam int unsigned IDX_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned HI_LSB   = WIN_BITS + IDX_BITS;
    localparam int unsigned TMR_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic [NUM_SLAVES-1:0]  s_valid_q, s_valid_d;
    logic [3:0]             s_wstrb_q, s_wstrb_d;
    logic [WIN_BITS-1:0]    s_addr_q, s_addr_d;
    logic [31:0]            s_wdata_q, s_wdata_d;
    logic                   m_ready_q, m_ready_d;
    logic [31:0]            m_rdata_q, m_rdata_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [7:0]             err_count_q, err_count_d;
    logic                   timeout_flag_q, timeout_flag_d;

    logic [IDX_BITS-1:0]    dec_idx;
    logic                   dec_hit;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;
    logic                   err_event;
    logic                   tmo_event;

    // Window decode: upper bits must match the base, index must name a real slave
    assign dec_idx = m_addr_i[WIN_BITS +: IDX_BITS];
    assign dec_hit = (m_addr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]) &&
                     ({1'b0, dec_idx} < (IDX_BITS + 1)'(NUM_SLAVES));

    // Mux the latched slave's ready/rdata; other slaves' ready is ignored
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == IDX_BITS'(k)) begin
                sel_ready = s_ready_i[k];
                sel_rdata = s_rdata_i[32*k +: 32];
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        s_valid_d      = s_valid_q;
        s_wstrb_d      = s_wstrb_q;
        s_addr_d       = s_addr_q;
        s_wdata_d      = s_wdata_q;
        m_ready_d      = 1'b0;
        m_rdata_d      = m_rdata_q;
        timer_d        = timer_q;
        err_event      = 1'b0;
        tmo_event      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m_valid_i && !m_ready_q) begin
                    if (dec_hit) begin
                        idx_d     = dec_idx;
                        s_addr_d  = m_addr_i[WIN_BITS-1:0];
                        s_wstrb_d = m_wstrb_i;
                        s_wdata_d = m_wdata_i;
                        s_valid_d = NUM_SLAVES'(1) << dec_idx;
                        timer_d   = '0;
                        state_d   = ST_ACCESS;
                    end else begin
                        m_rdata_d = ERR_DATA;
                        m_ready_d = 1'b1;
                        err_event = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // Slave completion takes priority over a timeout in the same cycle
                if (sel_ready) begin
                    m_rdata_d = sel_rdata;
                    s_valid_d = '0;
                    m_ready_d = 1'b1;
                    state_d   = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    m_rdata_d = ERR_DATA;
                    s_valid_d = '0;
                    m_ready_d = 1'b1;
                    err_event = 1'b1;
                    tmo_event = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Error bookkeeping; a clear in the same cycle as an error wins
        if (err_clear_i) begin
            err_count_d    = '0;
            timeout_flag_d = 1'b0;
        end else begin
            err_count_d    = (err_event && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
            timeout_flag_d = timeout_flag_q | tmo_event;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            s_valid_q      <= '0;
            s_wstrb_q      <= '0;
            s_addr_q       <= '0;
            s_wdata_q      <= '0;
            m_ready_q      <= 1'b0;
            m_rdata_q      <= '0;
            timer_q        <= '0;
            err_count_q    <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            s_valid_q      <= s_valid_d;
            s_wstrb_q      <= s_wstrb_d;
            s_addr_q       <= s_addr_d;
            s_wdata_q      <= s_wdata_d;
            m_ready_q      <= m_ready_d;
            m_rdata_q      <= m_rdata_d;
            timer_q        <= timer_d;
            err_count_q    <= err_count_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign m_ready_o      = m_ready_q;
    assign m_rdata_o      = m_rdata_q;
    assign s_valid_o      = s_valid_q;
    assign s_wstrb_o      = s_wstrb_q;
    assign s_addr_o       = s_addr_q;
    assign s_wdata_o      = s_wdata_q;
    assign err_count_o    = err_count_q;
    assign timeout_flag_o = timeout_flag_q;

endmodule

// File: tb/tb_iomem_periph_hub.sv
// Self-checking bench for iomem_periph_hub (4 slaves, TIMEOUT=8).
module tb_iomem_periph_hub;

    localparam int          NS   = 4;
    localparam int          TMO  = 8;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

    logic            clk;
    logic            reset;
    logic            m_valid;
    logic            m_ready;
    logic [3:0]      m_wstrb;
    logic [31:0]     m_addr;
    logic [31:0]     m_wdata;
    logic [31:0]     m_rdata;
    logic [NS-1:0]   s_valid;
    logic [3:0]      s_wstrb;
    logic [11:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [NS-1:0]   s_ready;
    logic [32*NS-1:0] s_rdata;
    logic            err_clear;
    logic [7:0]      err_count;
    logic            timeout_flag;

    int n_cmp = 0;
    int n_bad = 0;
    int m_errs = 0;     // reference error counter
    bit m_tflag = 0;    // reference sticky timeout flag

    iomem_periph_hub #(
        .NUM_SLAVES(NS), .BASE_ADDR(BASE), .WIN_BITS(12), .TIMEOUT(TMO), .ERR_DATA(ERR)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .m_valid_i(m_valid), .m_ready_o(m_ready), .m_wstrb_i(m_wstrb),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
        .s_valid_o(s_valid), .s_wstrb_o(s_wstrb), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_ready_i(s_ready), .s_rdata_i(s_rdata),
        .err_clear_i(err_clear), .err_count_o(err_count), .timeout_flag_o(timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Address map in plain arithmetic: four consecutive 4 KiB windows from BASE
    function automatic void ref_decode(input logic [31:0] addr, output bit hit,
                                       output int idx, output logic [11:0] off);
        longint a;
        a   = longint'(addr);
        hit = (a >= longint'(BASE)) && (a < longint'(BASE) + NS * 4096);
        idx = hit ? int'((a - longint'(BASE)) / 4096) : 0;
        off = 12'(a % 4096);
    endfunction

    function automatic void ref_error(input bit clr, input bit err, input bit tmo);
        if (clr) begin
            m_errs  = 0;
            m_tflag = 0;
        end
        if (err && !clr) begin
            if (m_errs < 255) m_errs++;
        end
        if (tmo && !clr) m_tflag = 1;
    endfunction

    // Master + responsive slave driver; delay<0 means the slave never answers.
    // err_clear (clr) is held only during the cycle the request is first seen.
    task automatic do_access(input logic [31:0] addr, input logic [3:0] wstrb,
                             input logic [31:0] wdata, input int delay,
                             input logic [31:0] srd, input bit drop, input bit clr,
                             output int lat, output logic [31:0] rd,
                             output logic [3:0] sv_first, output logic [11:0] sa,
                             output logic [3:0] sw, output logic [31:0] swd,
                             output bit stable, output int sv_cycles, output logic extra);
        int acc;
        logic [3:0] noise;
        lat = 0; rd = '0; acc = 0; sv_cycles = 0; stable = 1;
        sv_first = '0; sa = '0; sw = '0; swd = '0;
        @(negedge clk);
        m_valid = 1'b1; m_addr = addr; m_wstrb = wstrb; m_wdata = wdata;
        err_clear = clr; s_ready = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            err_clear = 1'b0;
            if (drop) m_valid = 1'b0;
            if (k == 1) begin
                sv_first = s_valid; sa = s_addr; sw = s_wstrb; swd = s_wdata;
            end
            if (s_valid !== 4'b0) begin
                sv_cycles++;
                if (s_valid !== sv_first || s_addr !== sa || s_wstrb !== sw || s_wdata !== swd)
                    stable = 0;
            end
            if (m_ready === 1'b1) begin
                lat = k; rd = m_rdata;
                break;
            end
            noise = 4'($urandom());
            for (int j = 0; j < NS; j++) s_rdata[32*j +: 32] = $urandom();
            if (s_valid !== 4'b0 && acc == delay) begin
                s_ready = s_valid | (noise & ~s_valid);
                for (int j = 0; j < NS; j++) if (s_valid[j]) s_rdata[32*j +: 32] = srd;
            end else begin
                s_ready = noise & ~s_valid;
            end
            if (s_valid !== 4'b0) acc++;
        end
        m_valid = 1'b0; s_ready = '0;
        @(posedge clk); #1;
        extra = m_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1; m_valid = 1'b0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
        s_ready = '0; s_rdata = '0; err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({m_ready, m_rdata} !== 33'h0) begin n_bad++; $display("FAIL reset_master: got %h want 0", {m_ready, m_rdata}); end
        n_cmp++; if ({s_valid, s_wstrb, s_addr, s_wdata} !== 52'h0) begin n_bad++; $display("FAIL reset_slave: got %h want 0", {s_valid, s_wstrb, s_addr, s_wdata}); end
        n_cmp++; if ({err_count, timeout_flag} !== 9'h0) begin n_bad++; $display("FAIL reset_err: got %h want 0", {err_count, timeout_flag}); end
        @(negedge clk);
        reset = 1'b0;
        m_errs = 0; m_tflag = 0;
    endtask

    task automatic test_read_slave2();
        int lat, svc; logic [31:0] rd, swd; logic [3:0] svf, sw; logic [11:0] sa; bit st; logic ex;
        do_access(32'h0300_2010, 4'b0000, 32'h0, 0, 32'h1234_5678, 0, 0, lat, rd, svf, sa, sw, swd, st, svc, ex);
        n_cmp++; if (svf !== 4'b0100) begin n_bad++; $display("FAIL rd2_svalid: got %b want 0100", svf); end
        n_cmp++; if (sa !== 12'h010) begin n_bad++; $display("FAIL rd2_saddr: got %h want 010", sa); end
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL rd2_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL rd2_rdata: got %h want 12345678", rd); end
        n_cmp++; if (ex !== 1'b0) begin n_bad++; $display("FAIL rd2_pulse: m_ready after RESP got %b want 0", ex); end
    endtask

    task automatic test_write_wait();
        int lat, svc; logic [31:0] rd, swd; logic [3:0] svf, sw; logic [11:0] sa; bit st; logic ex;
        do_access(32'h0300_0000, 4'b0011, 32'hCAFE_F00D, 5, 32'h0BAD_0001, 0, 0, lat, rd, svf, sa, sw, swd, st, svc, ex);
        n_cmp++; if (svf !== 4'b0001) begin n_bad++; $display("FAIL wr_svalid: got %b want 0001", svf); end
        n_cmp++; if (sw !== 4'b0011 || swd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL wr_payload: got %b/%h want 0011/cafef00d", sw, swd); end
        n_cmp++; if (!st || svc != 6) begin n_bad++; $display("FAIL wr_stable: got stable=%0d cycles=%0d want 1/6", st, svc); end
        n_cmp++; if (lat != 7) begin n_bad++; $display("FAIL wr_latency: got %0d want 7", lat); end
        n_cmp++; if (ex !== 1'b0) begin n_bad++; $display("FAIL wr_pulse: got %b want 0", ex); end
        n_cmp++; if (err_count !== 8'(m_errs)) begin n_bad++; $display("FAIL wr_errcnt: got %0d want %0d", err_count, m_errs); end
    endtask

    task automatic test_misses();
        int lat, svc; logic [31:0] rd, swd; logic [3:0] svf, sw; logic [11:0] sa; bit st; logic ex;
        logic [31:0] addrs [2];
        addrs[0] = 32'h0300_5000;
        addrs[1] = 32'h0400_0000;
        for (int i = 0; i < 2; i++) begin
            do_access(addrs[i], 4'b0000, 32'h0, 0, 32'h0, 0, 0, lat, rd, svf, sa, sw, swd, st, svc, ex);
            ref_error(0, 1, 0);
            n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL miss_latency: addr %h got %0d want 1", addrs[i], lat); end
            n_cmp++; if (rd !== ERR) begin n_bad++; $display("FAIL miss_rdata: got %h want %h", rd, ERR); end
            n_cmp++; if (svc != 0) begin n_bad++; $display("FAIL miss_svalid: got %0d cycles want 0", svc); end
        end
        n_cmp++; if (err_count !== 8'd2) begin n_bad++; $display("FAIL miss_errcnt: got %0d want 2", err_count); end
    endtask

    task automatic test_timeout();
        int lat, svc; logic [31:0] rd, swd; logic [3:0] svf, sw; logic [11:0] sa; bit st; logic ex;
        do_access(32'h0300_1004, 4'b0000, 32'h0, -1, 32'h0, 0, 0, lat, rd, svf, sa, sw, swd, st, svc, ex);
        ref_error(0, 1, 1);
        n_cmp++; if (lat != TMO + 1) begin n_bad++; $display("FAIL tmo_latency: got %0d want %0d", lat, TMO + 1); end
        n_cmp++; if (svc != TMO || svf !== 4'b0010) begin n_bad++; $display("FAIL tmo_svalid: got %b for %0d cycles want 0010 for %0d", svf, svc, TMO); end
        n_cmp++; if (rd !== ERR) begin n_bad++; $display("FAIL tmo_rdata: got %h want %h", rd, ERR); end
        n_cmp++; if (timeout_flag !== 1'b1 || err_count !== 8'(m_errs)) begin n_bad++; $display("FAIL tmo_err: got flag=%b cnt=%0d want 1/%0d", timeout_flag, err_count, m_errs); end
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        ref_error(1, 0, 0);
        n_cmp++; if (timeout_flag !== 1'b0 || err_count !== 8'd0) begin n_bad++; $display("FAIL tmo_clear: got flag=%b cnt=%0d want 0/0", timeout_flag, err_count); end
    endtask

    task automatic test_reset_mid();
        int lat, svc, seen; logic [31:0] rd, swd; logic [3:0] svf, sw; logic [11:0] sa; bit st; logic ex;
        // leave one error pending so reset has something to clear
        do_access(32'h0500_0000, 4'b0000, 32'h0, 0, 32'h0, 0, 0, lat, rd, svf, sa, sw, swd, st, svc, ex);
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h0300_1000; m_wstrb = 4'b1111; m_wdata = 32'h5555_AAAA;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (s_valid !== 4'b0010) begin n_bad++; $display("FAIL rstmid_access: got %b want 0010", s_valid); end
        @(negedge clk);
        reset = 1'b1; m_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata, err_count, timeout_flag} !== 94'h0)
            begin n_bad++; $display("FAIL rstmid_zero: got %h want 0", {m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata, err_count, timeout_flag}); end
        @(negedge clk);
        reset = 1'b0;
        m_errs = 0; m_tflag = 0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (m_ready === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstmid_noready: got %0d pulses want 0", seen); end
        do_access(32'h0300_3ABC, 4'b0000, 32'h0, 1, 32'h600D_F00D, 0, 0, lat, rd, svf, sa, sw, swd, st, svc, ex);
        n_cmp++; if (lat != 3 || rd !== 32'h600D_F00D || svf !== 4'b1000 || sa !== 12'hABC)
            begin n_bad++; $display("FAIL rstmid_after: got lat=%0d rd=%h sv=%b sa=%h want 3/600df00d/1000/abc", lat, rd, svf, sa); end
    endtask

    task automatic test_saturate();
        int lat, svc, wrong; logic [31:0] rd, swd; logic [3:0] svf, sw; logic [11:0] sa; bit st; logic ex;
        wrong = 0;
        for (int i = 0; i < 300; i++) begin
            do_access(32'hF000_0000 + 32'(i), 4'b0000, 32'h0, 0, 32'h0, 0, 0, lat, rd, svf, sa, sw, swd, st, svc, ex);
            ref_error(0, 1, 0);
            n_cmp++;
            if (err_count !== 8'(m_errs)) begin
                n_bad++;
                if (wrong < 4) $display("FAIL sat_count: miss %0d got %0d want %0d", i, err_count, m_errs);
                wrong++;
            end
        end
        n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL sat_final: got %0d want 255", err_count); end
        // clear arriving together with a new miss: clear wins
        do_access(32'h0000_0000, 4'b0000, 32'h0, 0, 32'h0, 0, 1, lat, rd, svf, sa, sw, swd, st, svc, ex);
        ref_error(1, 1, 0);
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL clear_wins: got %0d want 0", err_count); end
    endtask

    task automatic test_random();
        int lat, svc, delay, idx, elat, r; bit hit, st, drop, clr;
        logic [31:0] rd, swd, addr, wd, srd, erd; logic [3:0] svf, sw, ws; logic [11:0] sa, off; logic ex;
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       addr = BASE + (32'($urandom_range(0, 3)) << 12) + 32'($urandom_range(0, 4095));
            else if (r == 7) addr = BASE + (32'($urandom_range(4, 15)) << 12) + 32'($urandom_range(0, 4095));
            else if (r == 8) addr = $urandom();
            else             addr = BASE - 32'($urandom_range(1, 64));
            ws = 4'($urandom()); wd = $urandom(); srd = $urandom();
            delay = $urandom_range(0, 8);
            if (delay == 8) delay = -1;
            drop = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 7) == 0);
            do_access(addr, ws, wd, delay, srd, drop, clr, lat, rd, svf, sa, sw, swd, st, svc, ex);
            ref_decode(addr, hit, idx, off);
            if (!hit) begin
                elat = 1; erd = ERR; ref_error(clr, 1, 0);
            end else if (delay >= 0) begin
                elat = delay + 2; erd = srd; ref_error(clr, 0, 0);
            end else begin
                elat = TMO + 1; erd = ERR; ref_error(clr, 0, 0); ref_error(0, 1, 1);
            end
            n_cmp++; if (lat != elat || rd !== erd) begin n_bad++; $display("FAIL rnd_resp: it %0d addr %h got lat=%0d rd=%h want %0d/%h", it, addr, lat, rd, elat, erd); end
            n_cmp++; if (svc != (hit ? elat - 1 : 0)) begin n_bad++; $display("FAIL rnd_svcycles: it %0d got %0d want %0d", it, svc, hit ? elat - 1 : 0); end
            n_cmp++; if (ex !== 1'b0) begin n_bad++; $display("FAIL rnd_pulse: it %0d got %b want 0", it, ex); end
            n_cmp++; if (err_count !== 8'(m_errs) || timeout_flag !== m_tflag) begin n_bad++; $display("FAIL rnd_err: it %0d got %0d/%b want %0d/%b", it, err_count, timeout_flag, m_errs, m_tflag); end
            if (hit) begin
                n_cmp++;
                if (svf !== (4'b0001 << idx) || sa !== off || sw !== ws || swd !== wd || !st) begin
                    n_bad++;
                    $display("FAIL rnd_req: it %0d got sv=%b sa=%h ws=%b wd=%h st=%0d want %b/%h/%b/%h/1", it, svf, sa, sw, swd, st, 4'b0001 << idx, off, ws, wd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_slave2();
        test_write_wait();
        test_misses();
        test_timeout();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
